// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the mips_cpu_bus responder and CPU store path.
`default_nettype none

package mips_bus_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } resp_state_t;

   localparam int          WORD_BYTES   = 4;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   // Byte lane n of the result comes from new_word when be[n] is set.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int n = 0; n < WORD_BYTES; n++) begin
         if (be[n]) merged[8*n +: 8] = new_word[8*n +: 8];
      end
      return merged;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_bus_ram_array.sv
// Word-wide RAM: synchronous lane-masked write, registered read port that can return zero.
`default_nettype none

module mips_bus_ram_array
   import mips_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter     INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [3:0]            be_i,
   input  logic [ADDR_WIDTH-1:0] idx_i,
   input  logic [31:0]           wdata_i,
   input  logic                  re_i,
   input  logic                  rzero_i,
   output logic [31:0]           rdata_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem[idx_i] <= lane_merge(mem[idx_i], wdata_i, be_i);
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= rzero_i ? 32'h0 : mem[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mips_bus_mem_responder.sv
// Avalon-style memory responder for mips_cpu_bus: wait-state insertion, decode and sticky error flag.
`default_nettype none

module mips_bus_mem_responder
   import mips_bus_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
   parameter int          WAIT_CYCLES = 2,
   parameter              INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        bus_error
);

   localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

   resp_state_t state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [31:0] addr_q, addr_d;
   logic        op_q, op_d;
   logic        err_q, err_d;
   logic        accept;

   logic                  req;
   logic                  both;
   logic [31:0]           offset;
   logic                  decode_ok;
   logic [ADDR_WIDTH-1:0] idx;

   assign req       = read ^ write;
   assign both      = read & write;
   assign offset    = address - BASE_ADDR;
   assign decode_ok = ((offset >> (ADDR_WIDTH + 2)) == 32'h0) && (address[1:0] == 2'b00);
   assign idx       = offset[ADDR_WIDTH+1:2];

   assign waitrequest = req && (wcnt_q != WAIT_LIM);

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      err_d   = err_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (both) begin
               err_d  = 1'b1;
               wcnt_d = 4'd0;
            end else if (req) begin
               if (WAIT_LIM == 4'd0) begin
                  accept = 1'b1;
               end else begin
                  wcnt_d  = 4'd1;
                  addr_d  = address;
                  op_d    = read;
                  state_d = STALL;
               end
            end
         end
         STALL: begin
            // Master must hold its request steady until waitrequest drops.
            if (!req || (address != addr_q) || (read != op_q)) begin
               err_d   = 1'b1;
               wcnt_d  = 4'd0;
               state_d = IDLE;
            end else if (wcnt_q == WAIT_LIM) begin
               accept  = 1'b1;
               wcnt_d  = 4'd0;
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         default: begin
            wcnt_d  = 4'd0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
         addr_q  <= 32'h0;
         op_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         err_q   <= err_d | (accept & ~decode_ok);
      end
   end

   assign bus_error = err_q;

   mips_bus_ram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .rst     (reset),
      .we_i    (accept & write & decode_ok),
      .be_i    (byteenable),
      .idx_i   (idx),
      .wdata_i (writedata),
      .re_i    (accept & read),
      .rzero_i (~decode_ok),
      .rdata_o (readdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_mem_responder.sv
// Scoreboard bench for mips_bus_mem_responder with a 2-wait-state and a 0-wait-state instance.
`default_nettype none

module tb_mips_bus_mem_responder;

   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int          WAITA = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_read, a_write, a_wait, a_err;
   logic [31:0] a_addr, a_wd, a_rdata;
   logic [3:0]  a_be;
   logic        b_read, b_write, b_wait, b_err;
   logic [31:0] b_addr, b_wd, b_rdata;
   logic [3:0]  b_be;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_a[$];
   logic [31:0] sb_b[$];

   mips_bus_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITA), .INIT_FILE("")) u_dut_a (
      .clk(clk), .reset(rst), .address(a_addr), .read(a_read), .write(a_write),
      .byteenable(a_be), .writedata(a_wd), .waitrequest(a_wait), .readdata(a_rdata), .bus_error(a_err));

   mips_bus_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut_b (
      .clk(clk), .reset(rst), .address(b_addr), .read(b_read), .write(b_write),
      .byteenable(b_be), .writedata(b_wd), .waitrequest(b_wait), .readdata(b_rdata), .bus_error(b_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One full handshake on instance A; reads push the expected word and check it after accept.
   task automatic a_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp);
      int stalls;
      @(posedge clk); #1;
      a_read = rd; a_write = wr; a_addr = addr; a_be = be; a_wd = wd;
      stalls = 0;
      while (1) begin
         @(negedge clk);
         if (!a_wait) break;
         stalls++;
         if (stalls > 20) break;
      end
      chk("stall_cycles", 32'(stalls), (rd && wr) ? 32'd0 : 32'(WAITA));
      if (rd && !wr) sb_a.push_back(exp);
      @(posedge clk); #1;
      a_read = 1'b0; a_write = 1'b0;
      if (rd && !wr) begin
         @(negedge clk);
         chk("a_readdata", a_rdata, sb_a.pop_front());
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_read = 0; a_write = 0; a_addr = BASE; a_be = 4'hF; a_wd = 0;
      b_read = 0; b_write = 0; b_addr = BASE; b_be = 4'hF; b_wd = 0;
      repeat (2) @(negedge clk);
      chk("rst_a_rdata", a_rdata, 32'h0);
      chk("rst_a_err",   32'(a_err), 32'd0);
      chk("rst_a_wait",  32'(a_wait), 32'd0);
      chk("rst_b_rdata", b_rdata, 32'h0);
      chk("rst_b_err",   32'(b_err), 32'd0);
      rst = 1'b0;

      // Plain write then read with two wait states.
      a_op(0, 1, BASE, 4'hF, 32'h12345678, 32'h0);
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);
      chk("err_clean", 32'(a_err), 32'd0);

      // Reset lands mid-stall of a write: nothing committed.
      @(posedge clk); #1;
      a_write = 1'b1; a_addr = BASE; a_be = 4'hF; a_wd = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_stall_wait", 32'(a_wait), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdata", a_rdata, 32'h0);
      a_write = 1'b0;
      #1 chk("rst_idle_wait", 32'(a_wait), 32'd0);
      @(negedge clk); rst = 1'b0;
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);

      // Lane merge and zero byteenable.
      a_op(0, 1, BASE + 4, 4'hF, 32'h11223344, 32'h0);
      a_op(0, 1, BASE + 4, 4'b0101, 32'hAABBCCDD, 32'h0);
      a_op(1, 0, BASE + 4, 4'hF, 32'h0, 32'h11BB33DD);
      a_op(0, 1, BASE + 4, 4'b0000, 32'hFFFFFFFF, 32'h0);
      a_op(1, 0, BASE + 4, 4'hF, 32'h0, 32'h11BB33DD);
      chk("be0_no_err", 32'(a_err), 32'd0);

      // Out-of-range write (aliases word 0 if decode were wrong) is dropped and flagged.
      a_op(0, 1, BASE + 32'd4096, 4'hF, 32'h0BAD0BAD, 32'h0);
      chk("oor_err", 32'(a_err), 32'd1);
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);
      pulse_reset();

      // read && write together.
      a_op(1, 1, BASE, 4'hF, 32'h55555555, 32'h0);
      @(negedge clk);
      chk("both_err", 32'(a_err), 32'd1);
      pulse_reset();

      // Misaligned and unmapped reads return zero and set the error.
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);
      a_op(1, 0, BASE + 2, 4'hF, 32'h0, 32'h0);
      chk("misalign_err", 32'(a_err), 32'd1);
      pulse_reset();
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);
      a_op(1, 0, 32'h0, 4'hF, 32'h0, 32'h0);
      chk("unmapped_err", 32'(a_err), 32'd1);
      pulse_reset();

      // Read dropped mid-stall, then reissued.
      a_op(1, 0, BASE, 4'hF, 32'h0, 32'h12345678);
      @(posedge clk); #1;
      a_read = 1'b1; a_addr = BASE + 4;
      @(negedge clk);
      chk("drop_wait_hi", 32'(a_wait), 32'd1);
      @(posedge clk); #1;
      a_read = 1'b0;
      @(negedge clk);
      chk("drop_wait_lo", 32'(a_wait), 32'd0);
      @(negedge clk);
      chk("drop_err", 32'(a_err), 32'd1);
      chk("drop_rdata", a_rdata, 32'h12345678);
      a_op(1, 0, BASE + 4, 4'hF, 32'h0, 32'h11BB33DD);

      // Zero-wait instance: single-cycle writes and back-to-back reads.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         b_write = 1'b1; b_addr = BASE + 32'(4 * i); b_wd = 32'hC0DE0000 + 32'(i * 17);
         @(negedge clk);
         chk("b_wr_wait", 32'(b_wait), 32'd0);
      end
      @(posedge clk); #1;
      b_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         b_read = 1'b1; b_addr = BASE + 32'(4 * i);
         sb_b.push_back(32'hC0DE0000 + 32'(i * 17));
         @(negedge clk);
         chk("b_rd_wait", 32'(b_wait), 32'd0);
         if (i > 0) chk("b_readdata", b_rdata, sb_b.pop_front());
      end
      @(posedge clk); #1;
      b_read = 1'b0;
      @(negedge clk);
      chk("b_readdata", b_rdata, sb_b.pop_front());
      chk("b_err", 32'(b_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
